scrypt_nonce_sched: RTL and testbench

Nonce-sweep scheduler that sequences the scrypt hashing core over a range of candidate nonces. It holds a 76-byte block header, inserts each nonce in turn into the 80-byte core input, pulses the core's enable, and waits for the core's done. It stops on the first match, on exhaustion of the range, or on abort, and sits between the host/register interface and the scrypt core.

---
 rtl/scrypt_pkg.sv | 28 ++
 rtl/scrypt_nonce_sched.sv | 148 ++++++++++++++
 tb/tb_scrypt_nonce_sched.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scrypt_pkg
// Purpose  : Shared types, widths and helpers for the scrypt nonce scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package scrypt_pkg;

    localparam int NONCE_W = 32;   // nonce width
    localparam int HDR_W   = 608;  // block header width, nonce excluded
    localparam int DATA_W  = 640;  // full core input width

    // Scheduler states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } sched_state_t;

    // Byte reversal: the core expects the nonce little-endian in the header
    function automatic logic [31:0] bswap32(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scrypt_nonce_sched.sv
`default_nettype none
// ============================================================================
// Module   : scrypt_nonce_sched
// Purpose  : Sweeps a range of nonces through the scrypt core, one launch per
//            nonce, stopping on first match, range exhaustion or abort.
// Revision : 1.0 - initial release
// ============================================================================
module scrypt_nonce_sched
    import scrypt_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [HDR_W-1:0]     header_in,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [NONCE_W-1:0]   nonce_count,
    output logic [DATA_W-1:0]    core_data,
    output logic                 core_enable,
    input  logic                 core_hash_done,
    input  logic                 core_match_found,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [NONCE_W-1:0]   hashes_done
);

    sched_state_t         state_q,       state_d;
    logic [HDR_W-1:0]     hdr_q,         hdr_d;
    logic [NONCE_W-1:0]   nonce_q,       nonce_d;
    logic [NONCE_W-1:0]   rem_q,         rem_d;
    logic                 found_q,       found_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic [NONCE_W-1:0]   hashes_q,      hashes_d;

    // State and datapath registers; asynchronous reset shared with the core
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            hdr_q         <= '0;
            nonce_q       <= '0;
            rem_q         <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            hashes_q      <= '0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            nonce_q       <= nonce_d;
            rem_q         <= rem_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            hashes_q      <= hashes_d;
        end
    end

    // Next-state and datapath update; every register holds unless a state acts
    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        nonce_d       = nonce_q;
        rem_d         = rem_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        hashes_d      = hashes_q;

        case (state_q)
            S_IDLE: begin
                // abort held in IDLE suppresses a coincident start
                if (start && !abort) begin
                    hdr_d         = header_in;
                    nonce_d       = nonce_start;
                    rem_d         = nonce_count;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    hashes_d      = '0;
                    state_d       = (nonce_count == '0) ? S_FIN : S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                // The core is launched this cycle regardless of abort, so an
                // abort must wait out that hash in DRAIN. Any done seen here
                // belongs to an earlier launch and is dropped.
                state_d = abort ? S_DRAIN : S_WAIT;
            end

            S_WAIT: begin
                if (core_hash_done) begin
                    if (abort) begin
                        // Result of an aborted sweep is discarded
                        state_d = S_IDLE;
                    end else begin
                        hashes_d = hashes_q + NONCE_W'(1);
                        if (core_match_found) begin
                            found_d       = 1'b1;
                            found_nonce_d = nonce_q;
                            state_d       = S_FIN;
                        end else if (rem_q == NONCE_W'(1)) begin
                            state_d = S_FIN;
                        end else begin
                            nonce_d = nonce_q + NONCE_W'(1);
                            rem_d   = rem_q - NONCE_W'(1);
                            state_d = S_LAUNCH;
                        end
                    end
                end else if (abort) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (core_hash_done) begin
                    state_d = S_IDLE;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state only, so they are glitch-free
    always_comb begin
        core_enable = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE:   busy        = 1'b0;
            S_LAUNCH: core_enable = 1'b1;
            S_FIN:    done        = 1'b1;
            default:  busy        = 1'b1;
        endcase
    end

    assign core_data   = {hdr_q, bswap32(nonce_q)};
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign hashes_done = hashes_q;

endmodule
`default_nettype wire

// File: tb/tb_scrypt_nonce_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_scrypt_nonce_sched
// Purpose  : Self-checking bench for the scrypt nonce scheduler. Directed
//            scenarios plus randomized sweeps against a sweep-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scrypt_nonce_sched;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic [607:0]  header_in;
    logic [31:0]   nonce_start;
    logic [31:0]   nonce_count;
    logic [639:0]  core_data;
    logic          core_enable;
    logic          core_hash_done;
    logic          core_match_found;
    logic          busy;
    logic          done;
    logic          found;
    logic [31:0]   found_nonce;
    logic [31:0]   hashes_done;

    int checks = 0;
    int errors = 0;

    scrypt_nonce_sched dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .start            (start),
        .abort            (abort),
        .header_in        (header_in),
        .nonce_start      (nonce_start),
        .nonce_count      (nonce_count),
        .core_data        (core_data),
        .core_enable      (core_enable),
        .core_hash_done   (core_hash_done),
        .core_match_found (core_match_found),
        .busy             (busy),
        .done             (done),
        .found            (found),
        .found_nonce      (found_nonce),
        .hashes_done      (hashes_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [607:0] rand_hdr();
        logic [607:0] h = '0;
        for (int w = 0; w < 19; w++) h = {h[575:0], 32'($urandom())};
        return h;
    endfunction

    // Expected core input for a given header and nonce (nonce little-endian)
    function automatic logic [639:0] exp_data(input logic [607:0] h, input logic [31:0] n);
        logic [31:0] sw;
        sw = {<<8{n}};
        return {h, sw};
    endfunction

    // One full sweep. The model: nonces ns, ns+1, ... (mod 2^32) are launched
    // until the midx-th hash matches or cnt hashes have been done.
    task automatic run_sweep(input logic [607:0] hdr, input logic [31:0] ns,
                             input logic [31:0] cnt, input int midx, input int lat);
        int          k;
        bit          exp_found;
        logic [31:0] exp_fn;
        header_in   = hdr;
        nonce_start = ns;
        nonce_count = cnt;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs to show the captured copies are what is used
        header_in   = ~hdr;
        nonce_start = ns ^ 32'h5a5a_a5a5;
        nonce_count = cnt + 32'd7;
        if (cnt == 32'd0) begin
            chk("zero_done", done, 1);
            chk("zero_en", core_enable, 0);
            chk("zero_busy", busy, 1);
            chk("zero_found", found, 0);
            chk("zero_hashes", hashes_done, 0);
            @(negedge clk);
            chk("zero_busy_low", busy, 0);
            chk("zero_done_low", done, 0);
            return;
        end
        exp_found = (midx >= 1) && (32'(midx) <= cnt);
        k         = exp_found ? midx : int'(cnt);
        exp_fn    = exp_found ? ns + 32'(midx - 1) : 32'd0;
        for (int i = 0; i < k; i++) begin
            chk("launch_en", core_enable, 1);
            chk("launch_busy", busy, 1);
            chk("launch_no_done", done, 0);
            chk("launch_data", core_data, exp_data(hdr, ns + 32'(i)));
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                chk("wait_en_low", core_enable, 0);
                chk("wait_data_stable", core_data, exp_data(hdr, ns + 32'(i)));
            end
            core_hash_done   = 1'b1;
            core_match_found = (i + 1 == midx);
            @(negedge clk);
            core_hash_done   = 1'b0;
            core_match_found = 1'b0;
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 1);
        chk("end_en", core_enable, 0);
        chk("end_found", found, exp_found);
        chk("end_found_nonce", found_nonce, exp_fn);
        chk("end_hashes", hashes_done, k);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_found_held", found, exp_found);
        chk("post_hashes_held", hashes_done, k);
    endtask

    initial begin
        logic [607:0] h;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        header_in = '0; nonce_start = '0; nonce_count = '0;
        core_hash_done = 1'b0; core_match_found = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_en", core_enable, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_hashes", hashes_done, 0);
        chk("rst_data", core_data, 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Match on the 3rd hash
        run_sweep(rand_hdr(), 32'h10, 32'd4, 3, 3);
        // Zero count right after a match: found must clear
        run_sweep(rand_hdr(), 32'h5, 32'd0, 0, 1);
        // Exhaustion across the nonce wrap
        run_sweep(rand_hdr(), 32'hFFFF_FFFE, 32'd3, 0, 2);

        // Abort in WAIT, hash comes back much later with a match
        h = rand_hdr();
        header_in = h; nonce_start = 32'h100; nonce_count = 32'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ab_launch", core_enable, 1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("ab_drain_busy", busy, 1);
            chk("ab_drain_done", done, 0);
            chk("ab_drain_en", core_enable, 0);
            @(negedge clk);
        end
        core_hash_done = 1'b1; core_match_found = 1'b1;
        chk("ab_busy_at_hd", busy, 1);
        @(negedge clk); core_hash_done = 1'b0; core_match_found = 1'b0;
        chk("ab_busy_low", busy, 0);
        chk("ab_no_done", done, 0);
        chk("ab_found", found, 0);
        chk("ab_hashes", hashes_done, 0);
        @(negedge clk);
        chk("ab_no_late_done", done, 0);

        // Abort coincident with hash done in WAIT
        h = rand_hdr();
        header_in = h; nonce_start = 32'h200; nonce_count = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        chk("sc_relaunch", core_enable, 1);
        chk("sc_hashes1", hashes_done, 1);
        @(negedge clk);
        core_hash_done = 1'b1; core_match_found = 1'b1; abort = 1'b1;
        @(negedge clk); core_hash_done = 1'b0; core_match_found = 1'b0; abort = 1'b0;
        chk("sc_idle", busy, 0);
        chk("sc_hashes_kept", hashes_done, 1);
        chk("sc_found", found, 0);
        chk("sc_no_done", done, 0);

        // Stale done in LAUNCH, then abort in LAUNCH, start ignored in DRAIN
        h = rand_hdr();
        header_in = h; nonce_start = 32'h300; nonce_count = 32'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        chk("stale_hashes", hashes_done, 0);
        chk("stale_en", core_enable, 0);
        chk("stale_busy", busy, 1);
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        chk("la_relaunch", core_enable, 1);
        chk("la_data", core_data, exp_data(h, 32'h301));
        chk("la_hashes", hashes_done, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("la_drain_busy", busy, 1);
        chk("la_drain_en", core_enable, 0);
        nonce_count = 32'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("la_start_ignored", done, 0);
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        chk("la_idle", busy, 0);
        chk("la_hashes_kept", hashes_done, 1);
        @(negedge clk);
        chk("la_no_queued_start", busy, 0);

        // start while busy is ignored
        h = rand_hdr();
        header_in = h; nonce_start = 32'h400; nonce_count = 32'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        header_in = ~h; nonce_start = 32'hdead; nonce_count = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("bs_data_kept", core_data, exp_data(h, 32'h400));
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        chk("bs_data_next", core_data, exp_data(h, 32'h401));
        @(negedge clk);
        core_hash_done = 1'b1; core_match_found = 1'b1;
        @(negedge clk); core_hash_done = 1'b0; core_match_found = 1'b0;
        chk("bs_done", done, 1);
        chk("bs_found", found, 1);
        chk("bs_found_nonce", found_nonce, 32'h401);
        chk("bs_hashes", hashes_done, 2);
        @(negedge clk);
        chk("bs_idle", busy, 0);

        // abort in IDLE blocks start; results of last sweep stay held
        nonce_start = 32'h1; nonce_count = 32'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("ia_busy", busy, 0);
        chk("ia_en", core_enable, 0);
        chk("ia_found_held", found, 1);
        chk("ia_found_nonce_held", found_nonce, 32'h401);

        // Randomized sweeps
        for (int r = 0; r < 12; r++) begin
            logic [31:0] ns;
            ns = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                              : 32'($urandom());
            run_sweep(rand_hdr(), ns, 32'($urandom_range(0, 6)),
                      int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
        end

        // Asynchronous reset in the middle of WAIT
        h = rand_hdr();
        header_in = h; nonce_start = 32'h500; nonce_count = 32'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        core_hash_done = 1'b1;
        @(negedge clk); core_hash_done = 1'b0;
        @(negedge clk);
        chk("pre_rst_hashes", hashes_done, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_en", core_enable, 0);
        chk("arst_done", done, 0);
        chk("arst_found", found, 0);
        chk("arst_hashes", hashes_done, 0);
        chk("arst_data", core_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("arst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
